// File: rtl/sensor_pio_pkg.sv
// Register addresses and reset constants shared by the sensor event port.
package sensor_pio_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;

  localparam logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/sensor_event_pio_debounce.sv
// One sensor bit: 2-flop synchroniser, stability counter and accepted level.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic stable,
  output logic update
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // update is combinational so the edge register can capture on the same edge stable changes
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync   = sync_q;
  assign stable = stable_q;
endmodule

// File: rtl/sensor_event_pio.sv
// Debounced sensor input port with edge capture (W1C) and maskable level irq.
module sensor_event_pio
  import sensor_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [WIDTH-1:0] RISE_RST = RISE_EN_RST[WIDTH-1:0];

  logic [WIDTH-1:0] sync_w, stable_w, upd_w;
  logic [WIDTH-1:0] set_w, clr_w;
  logic             wr_en;
  logic             unused_wdata;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[gi]),
      .sync  (sync_w[gi]),
      .stable(stable_w[gi]),
      .update(upd_w[gi])
    );
  end

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect && !write_n;

  // On an update strobe, sync already holds the level stable is about to take
  assign set_w = (upd_w & sync_w & rise_en_q) | (upd_w & ~sync_w & fall_en_q);
  assign clr_w = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_en) begin
      case (address)
        ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
        ADDR_RISE_EN: rise_en_d = writedata[WIDTH-1:0];
        ADDR_FALL_EN: fall_en_d = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    edgecap_d = (edgecap_q & ~clr_w) | set_w;
    irq_d     = |(edgecap_q & irqmask_q);
    case (address)
      ADDR_DATA:    readdata_d = 32'(stable_w);
      ADDR_RAW:     readdata_d = 32'(sync_w);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      ADDR_RISE_EN: readdata_d = 32'(rise_en_q);
      ADDR_FALL_EN: readdata_d = 32'(fall_en_q);
      default:      readdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      rise_en_q  <= RISE_RST;
      fall_en_q  <= '0;
      readdata_q <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_sensor_event_pio.sv
// Scoreboard bench for sensor_event_pio with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_sensor_event_pio;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'h0;
  logic        irq;

  always #5 clk = ~clk;

  sensor_event_pio #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  logic rd_issue = 1'b0;
  logic rd_vld = 1'b0;

  // readdata for a read issued before edge N is presented after edge N
  always @(posedge clk) rd_vld <= rd_issue;

  always @(negedge clk) begin
    exp_t e;
    if (rd_vld) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: readdata=0x%08h with empty scoreboard", readdata);
      end else begin
        e = sb_q.pop_front();
        if (readdata !== e.exp) begin
          n_err++;
          $display("FAIL %s: readdata=0x%08h expected 0x%08h", e.nm, readdata, e.exp);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    x.exp = e;
    x.nm  = nm;
    sb_q.push_back(x);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_issue   = 1'b1;
    @(negedge clk);
    rd_issue   = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    n_checks++;
    if (irq !== e) begin
      n_err++;
      $display("FAIL %s: irq=%0b expected %0b", nm, irq, e);
    end
  endtask

  initial begin
    idle(3);
    reset = 1'b0;

    // reset state
    rd(3'd0, 32'h0, "rst_data");
    rd(3'd1, 32'h0, "rst_raw");
    rd(3'd2, 32'h0, "rst_irqmask");
    rd(3'd3, 32'h0, "rst_edgecap");
    rd(3'd4, 32'hF, "rst_rise_en");
    rd(3'd5, 32'h0, "rst_fall_en");
    chk_irq(1'b0, "rst_irq");

    // bit 0 rises: RAW after 2 edges, DATA after 6, irq one edge after capture
    wr(3'd2, 32'h1);
    in_port = 4'b0001;
    for (int j = 1; j <= 7; j++) begin
      if (j <= 3) rd(3'd1, (j >= 3) ? 32'h1 : 32'h0, $sformatf("raw_lat_%0d", j));
      else        rd(3'd0, (j >= 7) ? 32'h1 : 32'h0, $sformatf("data_lat_%0d", j));
      chk_irq(j >= 7, $sformatf("irq_lat_%0d", j));
    end
    rd(3'd3, 32'h1, "cap_rise");
    rd(3'd2, 32'h1, "irqmask_rb");
    wr(3'd3, 32'h1);
    chk_irq(1'b1, "irq_hold_after_clr");
    idle(1);
    chk_irq(1'b0, "irq_drop_after_clr");
    rd(3'd3, 32'h0, "cap_cleared");

    // 3-cycle glitch on bit 1 is filtered
    in_port = 4'b0011;
    idle(3);
    in_port = 4'b0001;
    idle(8);
    rd(3'd0, 32'h1, "glitch_data");
    rd(3'd3, 32'h0, "glitch_cap");
    chk_irq(1'b0, "glitch_irq");

    // falling-edge capture, W0 no-op, W1C
    wr(3'd5, 32'h1);
    wr(3'd4, 32'h0);
    rd(3'd4, 32'h0, "rise_en_rb");
    rd(3'd5, 32'h1, "fall_en_rb");
    in_port = 4'b0000;
    idle(8);
    rd(3'd0, 32'h0, "fall_data");
    rd(3'd3, 32'h1, "cap_fall");
    chk_irq(1'b1, "fall_irq");
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h1, "w0_noeffect");
    wr(3'd3, 32'h1);
    chk_irq(1'b1, "fall_irq_hold");
    idle(1);
    chk_irq(1'b0, "fall_irq_drop");
    rd(3'd3, 32'h0, "fall_cap_cleared");

    // W1C in the same cycle as a bit-2 rising update: set wins
    wr(3'd4, 32'hF);
    in_port = 4'b0100;
    idle(5);
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h4, "set_wins");
    chk_irq(1'b0, "unmasked_bit_no_irq");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "w1c_bit2");

    // reset in mid-debounce on bit 3 restarts the count
    in_port = 4'b1000;
    idle(4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    for (int j = 1; j <= 7; j++)
      rd(3'd0, (j >= 7) ? 32'h8 : 32'h0, $sformatf("rst_mid_data_%0d", j));
    rd(3'd3, 32'h8, "rst_mid_cap");
    rd(3'd2, 32'h0, "rst_mid_mask");
    chk_irq(1'b0, "rst_mid_irq");

    // opposite-direction edges on bits 3 and 0 in the same cycle
    wr(3'd5, 32'hF);
    wr(3'd3, 32'hF);
    in_port = 4'b0001;
    idle(8);
    rd(3'd0, 32'h1, "opp_data");
    rd(3'd3, 32'h9, "opp_cap");
    rd(3'd1, 32'h1, "opp_raw");
    rd(3'd6, 32'h0, "addr6_zero");
    wr(3'd7, 32'hF);
    rd(3'd7, 32'h0, "addr7_zero");

    idle(2);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d reads never returned, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
